// File: rtl/paralelo_serie.sv
// paralelo_serie -- byte-to-serial transmitter for the clk_8f byte-serial link.
//
// Bytes arrive over a valid/ready handshake into a one-entry buffer. They
// leave MSB first, one bit per clk_8f edge, in 8-edge byte slots. After reset
// SYNC_BYTES idle bytes are sent so the far-end receiver can lock. After
// that, any slot with no buffered byte carries IDLE_BYTE.
//
// Optional feature: define PARALELO_SERIE_BYTE_COUNT_EN to add tx_count, a
// 16-bit wrapping count of data bytes loaded from the buffer.
//
// Ports:
//   clk_8f       bit clock, one serial bit per rising edge
//   reset        asynchronous active-low reset
//   parallel_in  byte offered by the producer
//   valid_in     parallel_in is valid
//   ready_out    buffer can take a byte at the next edge (combinational)
//   data_out     serial bit, registered
//   byte_strobe  high while data_out carries bit 7 of a byte
//   active_out   high once the sync sequence has finished
//   tx_count     (optional) data bytes sent, wraps at 16 bits
//
// Parameters:
//   SYNC_BYTES   idle bytes sent after reset before data is accepted (1..7)
//   IDLE_BYTE    byte used for sync and for empty slots
//
// state  | meaning
// -------+---------------------------------------------------------------
// SYNC   | sending the post-reset idle bytes; buffer does not accept data
// ACTIVE | normal operation; buffered bytes fill slots, otherwise idle byte

module paralelo_serie #(
   parameter int unsigned SYNC_BYTES = 4,
   parameter logic [7:0]  IDLE_BYTE  = 8'hBC
) (
   input  logic        clk_8f,
   input  logic        reset,
   input  logic [7:0]  parallel_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        data_out,
   output logic        byte_strobe,
   output logic        active_out
`ifdef PARALELO_SERIE_BYTE_COUNT_EN
   ,
   output logic [15:0] tx_count
`endif
);

   localparam logic [2:0] SYNC_LAST = 3'(SYNC_BYTES - 1);

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t      state;
   logic [7:0]  byte_reg;
   logic [2:0]  bit_cnt;
   logic [7:0]  buf_reg;
   logic        buf_full;
   logic [2:0]  sync_cnt;

   logic        boundary;
   logic        wr_en;
   logic        load_buf;

   // The edge that shifts out bit 0 is also the edge that loads the next byte.
   assign boundary = (bit_cnt == 3'd0);

   // At a boundary a full buffer is being drained on this same edge, so it
   // can take a new byte.
   assign ready_out = (state == ST_ACTIVE) && (!buf_full || boundary);
   assign wr_en     = valid_in && ready_out;
   assign load_buf  = boundary && (state == ST_ACTIVE) && buf_full;

   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         state       <= ST_SYNC;
         active_out  <= 1'b0;
         bit_cnt     <= 3'd7;
         byte_reg    <= IDLE_BYTE;
         sync_cnt    <= 3'd0;
         buf_reg     <= 8'd0;
         buf_full    <= 1'b0;
         data_out    <= 1'b0;
         byte_strobe <= 1'b0;
      end else begin
         data_out    <= byte_reg[bit_cnt];
         byte_strobe <= (bit_cnt == 3'd7);
         bit_cnt     <= bit_cnt - 3'd1;

         if (boundary) begin
            case (state)
               ST_SYNC: begin
                  byte_reg <= IDLE_BYTE;
                  sync_cnt <= sync_cnt + 3'd1;
                  if (sync_cnt == SYNC_LAST) begin
                     state      <= ST_ACTIVE;
                     active_out <= 1'b1;
                  end
               end
               ST_ACTIVE: begin
                  // A byte written on this edge is not bypassed into
                  // byte_reg. It waits for the next slot.
                  if (buf_full) begin
                     byte_reg <= buf_reg;
                  end else begin
                     byte_reg <= IDLE_BYTE;
                  end
               end
               default: begin
                  state      <= ST_SYNC;
                  active_out <= 1'b0;
               end
            endcase
         end

         // A write on a consuming edge keeps buf_full set. The old byte has
         // already moved into byte_reg above.
         if (wr_en) begin
            buf_reg  <= parallel_in;
            buf_full <= 1'b1;
         end else if (load_buf) begin
            buf_full <= 1'b0;
         end
      end
   end

`ifdef PARALELO_SERIE_BYTE_COUNT_EN
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         tx_count <= 16'd0;
      end else if (load_buf) begin
         tx_count <= tx_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_paralelo_serie.sv
module tb_paralelo_serie;

   localparam logic [7:0] IDLE = 8'hBC;

   logic        clk_8f = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  parallel_in = 8'h00;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic        data_out;
   logic        byte_strobe;
   logic        active_out;
`ifdef PARALELO_SERIE_BYTE_COUNT_EN
   logic [15:0] tx_count;
`endif

   int errors = 0;
   int checks = 0;
   int edge_n = 0;

   typedef struct {
      int         start;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];

   paralelo_serie #(
      .SYNC_BYTES (4),
      .IDLE_BYTE  (8'hBC)
   ) dut (
      .clk_8f      (clk_8f),
      .reset       (reset),
      .parallel_in (parallel_in),
      .valid_in    (valid_in),
      .ready_out   (ready_out),
      .data_out    (data_out),
      .byte_strobe (byte_strobe),
      .active_out  (active_out)
`ifdef PARALELO_SERIE_BYTE_COUNT_EN
      ,
      .tx_count    (tx_count)
`endif
   );

   always #5 clk_8f = ~clk_8f;

   // Counts edges since reset release. Edge 1 sends bit 7 of the first byte.
   always @(posedge clk_8f or negedge reset) begin
      if (!reset) edge_n <= 0;
      else        edge_n <= edge_n + 1;
   end

   task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, actual, expected, edge_n, $time);
      end
   endtask

   // Monitor: rebuilds each byte slot from data_out and compares it with the
   // scoreboard entry that starts on that edge. Slots with no entry must be idle.
   initial begin : monitor
      logic [7:0] sh;
      logic [7:0] want;
      int         nb;
      int         st;
      bit         asm_on;
      sh = 8'h00; want = 8'h00; nb = 0; st = 0; asm_on = 1'b0;
      forever begin
         @(negedge clk_8f);
         #1;
         if (!reset) begin
            asm_on = 1'b0;
         end else if (edge_n > 0) begin
            check("strobe_phase", 16'(byte_strobe), 16'(((edge_n - 1) % 8) == 0));
            if (byte_strobe) begin
               asm_on = 1'b1;
               sh     = {7'b0, data_out};
               nb     = 1;
               st     = edge_n;
            end else if (asm_on) begin
               sh = {sh[6:0], data_out};
               nb++;
            end
            if (asm_on && nb == 8) begin
               if (exp_q.size() > 0 && exp_q[0].start == st) begin
                  want = exp_q[0].data;
                  void'(exp_q.pop_front());
               end else begin
                  want = IDLE;
               end
               check("slot_byte", 16'(sh), 16'(want));
               asm_on = 1'b0;
            end
         end
      end
   end

   // Drive a byte and hold it until accepted. A byte accepted at edge k is
   // loaded at the first boundary after k (a multiple of 8), so its bit 7
   // appears on the edge after that boundary.
   task automatic send_byte(input logic [7:0] b, input bit check_ready);
      int waited;
      bit acc;
      int k;
      waited = 0;
      parallel_in = b;
      valid_in    = 1'b1;
      forever begin
         acc = ready_out;
         k   = edge_n + 1;
         if (check_ready) check("ready_while_full", 16'(ready_out), 16'((k % 8) == 0));
         @(posedge clk_8f);
         if (acc) begin
            exp_q.push_back('{start: ((k / 8) + 1) * 8 + 1, data: b});
            @(negedge clk_8f);
            break;
         end
         @(negedge clk_8f);
         waited++;
         if (waited > 200) begin
            check("accept_timeout", 16'd0, 16'd1);
            break;
         end
      end
   endtask

   // Wait at negedges until the coming edge satisfies edge % 8 == p.
   task automatic wait_phase(input int p);
      for (int i = 0; i < 8 && ((edge_n + 1) % 8) != p; i++) @(negedge clk_8f);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data_out"}, 16'(data_out), 16'd0);
      check({tag, "_strobe"},   16'(byte_strobe), 16'd0);
      check({tag, "_active"},   16'(active_out), 16'd0);
      check({tag, "_ready"},    16'(ready_out), 16'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      // Reset, then sync sequence: 5 idle bytes in 40 edges, ready/active at 32.
      repeat (3) @(negedge clk_8f);
      #1;
      check_reset_outputs("por");
      @(negedge clk_8f);
      reset = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk_8f);
         check("sync_active", 16'(active_out), 16'(edge_n >= 32));
         check("sync_ready",  16'(ready_out),  16'(edge_n >= 32));
      end

      // Back-to-back 0xA5, 0x3C with valid held. Ready stays low while the
      // buffer is full and comes back on the boundary edge.
      wait_phase(5);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h3C, 1'b1);
      valid_in = 1'b0;
      repeat (24) @(negedge clk_8f);

      // 0x81 written into an empty buffer on a boundary edge: the current
      // slot stays idle and 0x81 follows in the next slot.
      wait_phase(0);
      check("ready_empty_boundary", 16'(ready_out), 16'd1);
      send_byte(8'h81, 1'b0);
      valid_in = 1'b0;
      repeat (20) @(negedge clk_8f);

      // Reset mid-byte with 0xFF buffered. 0xFF must never be sent.
      wait_phase(3);
      send_byte(8'hFF, 1'b0);
      valid_in = 1'b0;
      repeat (2) @(negedge clk_8f);
      reset = 1'b0;
      exp_q.delete();
      #1;
      check_reset_outputs("mid");
      repeat (2) @(negedge clk_8f);
      reset = 1'b1;
      repeat (40) @(negedge clk_8f);
      check("resync_active", 16'(active_out), 16'd1);

      // Loopback data, including a byte equal to the idle pattern.
      send_byte(8'h00, 1'b0);
      send_byte(8'hBC, 1'b0);
      send_byte(8'h7E, 1'b0);
      valid_in = 1'b0;
      for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk_8f);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      repeat (16) @(negedge clk_8f);

`ifdef PARALELO_SERIE_BYTE_COUNT_EN
      check("tx_count", tx_count, 16'd3);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
